var_deshift: RTL and testbench
==============================

VAR_DESHIFT -- requirements
Module: var_deshift

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the maximum word length in bits.
REQ-002 SHALL have parameter LW, default 6, giving the width of len; LW SHALL equal clog2(WIDTH)+1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 clr  input  1  reset; synchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a new word; sampled only in IDLE.
REQ-006 len  input  LW  number of bits in the word, valid range 1..WIDTH; sampled with start.
REQ-007 dir  input  1  bit order, sampled with start: 0 = MSB-first, 1 = LSB-first.
REQ-008 sin  input  1  serial data bit.
REQ-009 sin_vld  input  1  qualifies sin; a bit is consumed only when sin_vld=1 in SHIFT.
REQ-010 q  output  WIDTH  assembled word, right-justified, with unused upper bits zero.
REQ-011 q_vld  output  1  q holds a completed word.
REQ-012 q_rdy  input  1  consumer accepts q; a transfer occurs when q_vld and q_rdy are both 1 on the same edge.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 err  output  1  one-cycle pulse flagging a rejected start.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, SHIFT, HOLD.
REQ-016 IDLE, start=1, len in 1..WIDTH: SHALL latch len and dir, clear the shift register and bit counter, and go to SHIFT.
REQ-017 IDLE, start=1, len=0 or len>WIDTH: SHALL pulse err for one cycle and stay in IDLE, leaving q unchanged.
REQ-018 SHIFT, sin_vld=1, dir=0: SHALL shift the register left and insert sin at bit 0.
REQ-019 SHIFT, sin_vld=1, dir=1: SHALL shift the register right and insert sin at bit WIDTH-1.
REQ-020 SHIFT, sin_vld=1: SHALL increment the counter; sin_vld=0 SHALL hold the register and counter unchanged, with no timeout.
REQ-021 SHALL treat the bit consumed when the counter equals len-1 as the last bit.
REQ-022 On the last bit, SHALL go to HOLD and load q on the same edge:
- dir=0: q = register contents.
- dir=1: q = register shifted right by WIDTH-len.
- Either case: bits at len and above are zero.
REQ-023 SHALL assert q_vld on the first cycle after the last bit is consumed (latency 1 cycle from the last sin_vld edge).
REQ-024 HOLD: q and q_vld SHALL remain stable until a transfer; sin and sin_vld SHALL be ignored.
REQ-025 HOLD, q_rdy=1: SHALL complete the transfer and go to IDLE, deasserting q_vld on the next cycle; q SHALL retain its value.
REQ-026 start SHALL be ignored while busy=1, with no err pulse.
REQ-027 SHALL handle len=WIDTH as a full-width word: the counter SHALL reach WIDTH-1 without overflow, with no alignment shift.
REQ-028 SHALL handle len=1 as a single bit: go to HOLD after one consumed bit, with q = {0..., sin}.
REQ-029 SHALL accept back-to-back words: start may be asserted in the cycle after the transfer (first IDLE cycle).

Reset
REQ-030 clr=0 on a rising edge SHALL force, on that edge:
- state to IDLE;
- q=0, q_vld=0, busy=0, err=0;
- shift register, counter, and latched len/dir to 0.
REQ-031 Reset SHALL take priority over every other input, including mid-SHIFT and mid-HOLD, and SHALL discard any partial word.
REQ-032 The first edge with clr=1 SHALL accept start.

Verification
REQ-033 The bench SHALL cover:
- len=32, dir=0, bits of 0x7105C1A6 sent MSB-first with sin_vld=1 throughout -> q=0x7105C1A6, q_vld rising exactly 1 cycle after the 32nd bit.
- len=11, dir=1, bits of 0x5A3 sent LSB-first with 3 idle sin_vld=0 cycles mid-word -> q=0x000005A3, busy high from start until the transfer.
- len=0 start, then len=33 start -> err pulses once per start, busy stays 0, q unchanged.
- Completed word with q_rdy=0 for 5 cycles -> q, q_vld stable; a second start is ignored; q_rdy=1 -> IDLE next cycle.
- clr=0 after 7 of 16 bits -> q=0, q_vld=0, busy=0; a new len=4, dir=0 word of 1011 -> q=0x0000000B.
- len=1, dir=1, sin=1 -> q=0x00000001; back-to-back start on the first IDLE cycle is accepted.

Source files
------------

// File: rtl/var_deshift.sv
`default_nettype none
// ============================================================================
//  Module   : var_deshift
//  Purpose  : Variable-length serial-to-parallel deserializer. A word of
//             1..WIDTH bits is collected MSB-first or LSB-first and presented
//             right-justified on q with a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1      clock, rising edge
//    clr      in   1      synchronous reset, active low
//    start    in   1      begin a new word (sampled in IDLE only)
//    len      in   LW     word length, legal range 1..WIDTH
//    dir      in   1      0 = MSB-first, 1 = LSB-first
//    sin      in   1      serial data
//    sin_vld  in   1      qualifies sin
//    q        out  WIDTH  assembled word, right-justified, upper bits zero
//    q_vld    out  1      q holds a completed word
//    q_rdy    in   1      consumer accepts q
//    busy     out  1      state is not IDLE
//    err      out  1      one-cycle pulse on a rejected start
// ============================================================================
module var_deshift #(
  parameter int WIDTH = 32,
  parameter int LW    = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [LW-1:0]    len,
  input  logic             dir,
  input  logic             sin,
  input  logic             sin_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld,
  input  logic             q_rdy,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [LW-1:0] C_WIDTH = LW'(WIDTH);
  localparam logic [LW-1:0] C_ONE   = LW'(1);

  logic [1:0]       state_q, state_d;
  logic [LW-1:0]    len_q,   len_d;
  logic             dir_q,   dir_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [LW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic             err_q,   err_d;

  logic             w_len_ok;
  logic             w_take;
  logic             w_last;
  logic [WIDTH-1:0] w_sreg_shift;
  logic [LW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_aligned;

  // A requested length is legal only in 1..WIDTH.
  assign w_len_ok = (len != '0) && (len <= C_WIDTH);

  // A bit is consumed only while shifting and qualified by sin_vld.
  assign w_take = (state_q == S_SHIFT) && sin_vld;
  assign w_last = w_take && (cnt_q == (len_q - C_ONE));

  // MSB-first words grow from bit 0 upward; LSB-first words enter at the
  // top and walk downward, so they end up left-justified in the register.
  assign w_sreg_shift = dir_q ? {sin, sreg_q[WIDTH-1:1]}
                              : {sreg_q[WIDTH-2:0], sin};

  // LSB-first words need right-justifying by the unused bit count. For a
  // full-width word the shift amount is zero. MSB-first words are already
  // right-justified with zero upper bits since the register starts cleared.
  assign w_shamt   = C_WIDTH - len_q;
  assign w_aligned = dir_q ? (w_sreg_shift >> w_shamt) : w_sreg_shift;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && w_len_ok) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (q_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy  = (state_q != S_IDLE);
    q_vld = (state_q == S_HOLD);
    q     = word_q;
    err   = err_q;
  end

  // --------------------------------------------------------------------------
  // Datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    len_d  = len_q;
    dir_d  = dir_q;
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    word_d = word_q;
    err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            len_d  = len;
            dir_d  = dir;
            sreg_d = '0;
            cnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (w_take) begin
          sreg_d = w_sreg_shift;
          // cnt reaches len on the last bit; len <= WIDTH fits in LW bits.
          cnt_d  = cnt_q + C_ONE;
          if (w_last) begin
            word_d = w_aligned;
          end
        end
      end
      default: begin
        // HOLD keeps everything; q is retained after the transfer too.
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr) begin
      len_q  <= '0;
      dir_q  <= 1'b0;
      sreg_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      dir_q  <= dir_d;
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      word_q <= word_d;
      err_q  <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_var_deshift.sv
`default_nettype none
// ============================================================================
//  Module   : tb_var_deshift
//  Purpose  : Self-checking bench for var_deshift. Expected words are queued
//             when their last bit is driven and compared when the DUT
//             transfers them (q_vld & q_rdy).
//  Revision : 1.0  initial release
// ============================================================================
module tb_var_deshift;

  localparam int WIDTH = 32;
  localparam int LW    = 6;

  logic             clk;
  logic             clr;
  logic             start;
  logic [LW-1:0]    len;
  logic             dir;
  logic             sin;
  logic             sin_vld;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic             q_rdy;
  logic             busy;
  logic             err;

  int checks = 0;
  int errors = 0;
  int n_push = 0;
  int n_pop  = 0;

  logic [WIDTH-1:0] sb[$];

  var_deshift #(.WIDTH(WIDTH), .LW(LW)) u_dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .len     (len),
    .dir     (dir),
    .sin     (sin),
    .sin_vld (sin_vld),
    .q       (q),
    .q_vld   (q_vld),
    .q_rdy   (q_rdy),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every transfer pops the oldest expected word.
  always @(negedge clk) begin
    if (clr && q_vld && q_rdy) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(q), 64'hDEAD_BEEF);
      end else begin
        chk("sb_word", 64'(q), 64'(sb.pop_front()));
        n_pop++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] masked(input logic [WIDTH-1:0] v, input int l);
    logic [63:0] m;
    m = (64'd1 << l) - 64'd1;
    return v & m[WIDTH-1:0];
  endfunction

  task automatic start_word(input int l, input logic d);
    start = 1'b1;
    len   = LW'(l);
    dir   = d;
    tick();
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
  endtask

  // Send l bits of v in the order given by d; optional idle gap after bit gap_at.
  task automatic send_bits(input int l, input logic d, input logic [WIDTH-1:0] v,
                           input int gap_at, input int gap_len);
    int idx;
    for (int i = 0; i < l; i++) begin
      idx     = d ? i : (l - 1 - i);
      sin     = v[idx];
      sin_vld = 1'b1;
      if (i == l - 1) begin
        sb.push_back(masked(v, l));
        n_push++;
      end
      tick();
      if (i == l - 2) chk("pre_last_vld", 64'(q_vld), 64'd0);
      if (i == gap_at && i != l - 1) begin
        sin_vld = 1'b0;
        sin     = ~sin;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          chk("gap_busy", 64'(busy), 64'd1);
        end
      end
    end
    sin_vld = 1'b0;
    chk("lat_vld", 64'(q_vld), 64'd1);
  endtask

  task automatic transfer();
    q_rdy = 1'b1;
    tick();
    q_rdy = 1'b0;
    chk("xfer_vld", 64'(q_vld), 64'd0);
    chk("xfer_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] held;
    int               rl;
    logic             rd;
    logic [WIDTH-1:0] rv;

    clr = 1'b0; start = 1'b0; len = '0; dir = 1'b0;
    sin = 1'b0; sin_vld = 1'b0; q_rdy = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_vld", 64'(q_vld), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    clr = 1'b1;

    // Full-width MSB-first word
    start_word(32, 1'b0);
    send_bits(32, 1'b0, 32'h7105C1A6, -1, 0);
    chk("w32_q", 64'(q), 64'h7105C1A6);
    transfer();

    // 11-bit LSB-first word with a 3-cycle gap mid-word
    start_word(11, 1'b1);
    send_bits(11, 1'b1, 32'h5A3, 5, 3);
    chk("w11_busy_hold", 64'(busy), 64'd1);
    transfer();
    chk("w11_q_retained", 64'(q), 64'h5A3);

    // Illegal lengths
    held  = q;
    start = 1'b1; len = '0; dir = 1'b0;
    tick();
    start = 1'b0;
    chk("len0_err", 64'(err), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    tick();
    chk("len0_err_clr", 64'(err), 64'd0);
    start = 1'b1; len = 6'd33;
    tick();
    start = 1'b0;
    chk("len33_err", 64'(err), 64'd1);
    chk("len33_busy", 64'(busy), 64'd0);
    tick();
    chk("len33_err_clr", 64'(err), 64'd0);
    chk("bad_q_kept", 64'(q), 64'(held));

    // Back-pressure in HOLD, start and sin ignored
    start_word(8, 1'b0);
    send_bits(8, 1'b0, 32'hC3, -1, 0);
    for (int c = 0; c < 5; c++) begin
      sin     = 1'(c);
      sin_vld = 1'b1;
      start   = (c == 2);
      len     = 6'd4;
      tick();
      start   = 1'b0;
      chk("hold_q", 64'(q), 64'hC3);
      chk("hold_vld", 64'(q_vld), 64'd1);
      chk("hold_err", 64'(err), 64'd0);
    end
    sin_vld = 1'b0;
    transfer();
    chk("hold_q_after", 64'(q), 64'hC3);

    // Reset mid-word discards it
    start_word(16, 1'b0);
    for (int i = 0; i < 7; i++) begin
      sin = 1'b1; sin_vld = 1'b1;
      tick();
    end
    sin_vld = 1'b0;
    clr = 1'b0;
    tick();
    clr = 1'b1;
    chk("mrst_q", 64'(q), 64'd0);
    chk("mrst_vld", 64'(q_vld), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    start_word(4, 1'b0);
    send_bits(4, 1'b0, 32'hB, -1, 0);
    chk("w4_q", 64'(q), 64'hB);
    transfer();

    // Single-bit word, then back-to-back start on the first IDLE cycle
    start_word(1, 1'b1);
    send_bits(1, 1'b1, 32'h1, -1, 0);
    chk("w1_q", 64'(q), 64'h1);
    transfer();
    start_word(5, 1'b0);
    send_bits(5, 1'b0, 32'h15, -1, 0);
    transfer();

    // A few random words
    for (int k = 0; k < 6; k++) begin
      rl = $urandom_range(1, WIDTH);
      rd = 1'($urandom_range(0, 1));
      rv = $urandom;
      start_word(rl, rd);
      send_bits(rl, rd, rv, (rl > 2) ? $urandom_range(0, rl - 2) : -1, $urandom_range(0, 3));
      transfer();
    end

    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("sb_count", 64'(n_pop), 64'(n_push));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
